// File: rtl/udma_eth_frame_tx.sv
// -----------------------------------------------------------------------------
// udma_eth_frame_tx
//
// Transmit-side datapath of the uDMA ethernet-frame peripheral. A frame is
// started by a byte-count command (set_tx_bytes_i / tx_bytes_i). The block
// pulls 32-bit words from the uDMA TX channel and serialises them
// little-endian (byte 0 = bits [7:0]) into an 8-bit stream toward the MAC.
// The final byte of the frame is flagged with eth_tx_last_o.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. A valid source holds data and all qualifiers stable until the
// transfer happens. Ready may change freely and never depends on valid in the
// same cycle.
//
// Optional build macro:
//   ETH_TX_IFG_EN - after the last byte, hold off for IFG_CYCLES cycles in a
//                   GAP state (tx_busy_o stays 1) before returning to IDLE.
//                   Without the macro the last byte returns straight to IDLE.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   set_tx_bytes_i     start pulse for a frame of tx_bytes_i bytes
//   tx_bytes_i         frame length, sampled with set_tx_bytes_i
//   tx_bytes_left_o    bytes of the current frame not yet accepted by the MAC
//   data_tx_i/_valid_i/_ready_o   32-bit word stream from the uDMA channel
//   eth_tx_data_o/_valid_o/_last_o/_ready_i   8-bit stream to the MAC
//   tx_busy_o          frame in progress (state != IDLE)
//   tx_done_o          one-cycle pulse the cycle after the last-byte transfer
//   tx_overrun_o       one-cycle pulse: a start command was dropped (not IDLE)
//   dbg_state_o        current FSM state (IDLE=0, FETCH=1, SEND=2, GAP=3)
// -----------------------------------------------------------------------------
module udma_eth_frame_tx #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,

  input  logic                 set_tx_bytes_i,
  input  logic [CNT_WIDTH-1:0] tx_bytes_i,
  output logic [CNT_WIDTH-1:0] tx_bytes_left_o,

  input  logic [31:0]          data_tx_i,
  input  logic                 data_tx_valid_i,
  output logic                 data_tx_ready_o,

  output logic [7:0]           eth_tx_data_o,
  output logic                 eth_tx_valid_o,
  output logic                 eth_tx_last_o,
  input  logic                 eth_tx_ready_i,

  output logic                 tx_busy_o,
  output logic                 tx_done_o,
  output logic                 tx_overrun_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // The gap counter is 16 bits wide; a larger IFG_CYCLES would silently
  // truncate, so reject it at elaboration.
  if (IFG_CYCLES > 32'h0000_FFFF) begin : g_ifg_range_check
    $error("IFG_CYCLES must fit in 16 bits");
  end

  state_e               state_q, state_d;
  logic [31:0]          word_q, word_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] left_q, left_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic word_hs;
  logic send_hs;
  logic last_byte;
  logic start_frame;

  assign word_hs     = (state_q == ST_FETCH) && data_tx_valid_i;
  assign send_hs     = (state_q == ST_SEND) && eth_tx_ready_i;
  assign last_byte   = (left_q == CNT_WIDTH'(1));
  assign start_frame = (state_q == ST_IDLE) && set_tx_bytes_i &&
                       (tx_bytes_i != '0);

`ifdef ETH_TX_IFG_EN
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        gap_over;

  // The counter is loaded with IFG_CYCLES on GAP entry and the FSM leaves GAP
  // in the cycle the counter reads 1 (or 0), so GAP lasts IFG_CYCLES cycles,
  // with a minimum of one cycle.
  assign gap_over = (gap_cnt_q <= 16'd1);

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (send_hs && last_byte) begin
      gap_cnt_d = 16'(IFG_CYCLES);
    end else if ((state_q == ST_GAP) && (gap_cnt_q != 16'd0)) begin
      gap_cnt_d = gap_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gap_cnt_q <= 16'd0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (data_tx_valid_i) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (eth_tx_ready_i) begin
          if (last_byte) begin
`ifdef ETH_TX_IFG_EN
            state_d = ST_GAP;
`else
            state_d = ST_IDLE;
`endif
          end else if (idx_q == 2'd3) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
`ifdef ETH_TX_IFG_EN
        if (gap_over) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_tx_ready_o = (state_q == ST_FETCH);
    eth_tx_valid_o  = (state_q == ST_SEND);
    eth_tx_last_o   = (state_q == ST_SEND) && last_byte;
    eth_tx_data_o   = word_q[{idx_q, 3'b000} +: 8];
    tx_busy_o       = (state_q != ST_IDLE);
    dbg_state_o     = state_q;
  end

  assign tx_bytes_left_o = left_q;
  assign tx_done_o       = done_q;
  assign tx_overrun_o    = overrun_q;

  // ---------------------------------------------------------------------------
  // Datapath: word buffer, byte index, remaining count, status pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    word_d    = word_q;
    idx_d     = idx_q;
    left_d    = left_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    // Commands are only taken in IDLE; anything else is dropped and flagged.
    // This includes the cycle of the last-byte transfer, because the FSM is
    // still in SEND then.
    if (set_tx_bytes_i) begin
      if (state_q != ST_IDLE) begin
        overrun_d = 1'b1;
      end else if (tx_bytes_i != '0) begin
        left_d = tx_bytes_i;
      end
    end

    if (word_hs) begin
      word_d = data_tx_i;
      idx_d  = 2'd0;
    end

    // left_q is at least 1 in SEND, so the count never wraps.
    if (send_hs && (left_q != '0)) begin
      left_d = left_q - CNT_WIDTH'(1);
      idx_d  = idx_q + 2'd1;
      done_d = last_byte;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_q    <= 32'd0;
      idx_q     <= 2'd0;
      left_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      idx_q     <= idx_d;
      left_q    <= left_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
